// File: rtl/agen_stage_pkg.sv
// agen_stage_pkg
// Shared types and constants for the address-generation stage:
//   - datapath widths
//   - misalignment exception cause codes
//   - access size encoding
//   - agenPkt, the payload held in the OUT and SKID registers
//   - isMisaligned(), the natural-alignment test
package agen_stage_pkg;

  localparam int DATA_W  = 64;
  localparam int VADDR_W = 39;
  localparam int AL_W    = 7;
  localparam int PHY_W   = 7;
  localparam int LSQ_W   = 5;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } memSizeE;

  typedef struct packed {
    logic [VADDR_W-1:0] addr;
    memSizeE            size;
    logic               isLoad;
    logic               isSigned;
    logic [DATA_W-1:0]  stData;
    logic [LSQ_W-1:0]   lsqId;
    logic [AL_W-1:0]    alId;
    logic [PHY_W-1:0]   phyDest;
  } agenPkt;

  // An access is misaligned when any address bit below its size is set.
  // Only the low three address bits are needed for the largest access.
  function automatic logic isMisaligned(input memSizeE sz, input logic [2:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_HALF:   bad = addrLo[0];
      SZ_WORD:   bad = |addrLo[1:0];
      SZ_DOUBLE: bad = |addrLo[2:0];
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/agen_skid_buf.sv
// agen_skid_buf
// Two-entry valid/ready holding register (OUT plus SKID).
//   clk, reset   clock and asynchronous active-high reset
//   flush        synchronous kill of both entries and of any op accepted this cycle
//   inValid      upstream offers a payload
//   inReady      registered; high whenever SKID is empty
//   inData       upstream payload
//   outValid     OUT holds a payload
//   outReady     downstream accepts OUT this cycle
//   outData      OUT payload (held stable while outValid && !outReady)
module agen_skid_buf
  import agen_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  logic         outValidReg,  outValidNext;
  logic         skidValidReg, skidValidNext;
  logic         readyReg,     readyNext;
  logic [W-1:0] outDataReg,   outDataNext;
  logic [W-1:0] skidDataReg,  skidDataNext;
  logic         drain;
  logic         accept;

  assign drain  = outValidReg && outReady;
  assign accept = inValid && readyReg;

  always_comb begin
    outValidNext  = outValidReg;
    skidValidNext = skidValidReg;
    outDataNext   = outDataReg;
    skidDataNext  = skidDataReg;

    if (drain) begin
      // An accept can only coincide with a full SKID when readyReg is
      // stale-high, which never happens, so SKID refill is not needed here.
      if (skidValidReg) begin
        outDataNext   = skidDataReg;
        skidValidNext = 1'b0;
      end else if (accept) begin
        outDataNext = inData;
      end else begin
        outValidNext = 1'b0;
      end
    end else if (accept) begin
      if (!outValidReg) begin
        outValidNext = 1'b1;
        outDataNext  = inData;
      end else begin
        skidValidNext = 1'b1;
        skidDataNext  = inData;
      end
    end

    if (flush) begin
      outValidNext  = 1'b0;
      skidValidNext = 1'b0;
    end

    // Ready is a function of next-cycle SKID state only, so it never
    // depends combinationally on outReady.
    readyNext = !skidValidNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValidReg  <= 1'b0;
      skidValidReg <= 1'b0;
      readyReg     <= 1'b1;
      outDataReg   <= '0;
      skidDataReg  <= '0;
    end else begin
      outValidReg  <= outValidNext;
      skidValidReg <= skidValidNext;
      readyReg     <= readyNext;
      outDataReg   <= outDataNext;
      skidDataReg  <= skidDataNext;
    end
  end

  assign inReady  = readyReg;
  assign outValid = outValidReg;
  assign outData  = outDataReg;

endmodule

// File: rtl/agen_stage.sv
// agen_stage
// Address-generation stage feeding the LSU. Computes base + signed offset
// truncated to VADDR_W, checks natural alignment, sends aligned ops to the
// LSU through a two-entry holding buffer and diverts misaligned ops to a
// one-cycle exception pulse.
//   clk, reset, recoverFlag_i        clock, async reset, pipeline flush
//   issue*_i / issueReady_o          memory issue lane handshake and operands
//   mem*_o / memReady_i              registered memory packet to the LSU
//   exc*_o                           misalignment exception (cause, tval, AL ID)
module agen_stage
  import agen_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               recoverFlag_i,
  input  logic               issueValid_i,
  output logic               issueReady_o,
  input  logic [DATA_W-1:0]  issueBase_i,
  input  logic [11:0]        issueOffset_i,
  input  logic [1:0]         issueSize_i,
  input  logic               issueIsLoad_i,
  input  logic               issueIsSigned_i,
  input  logic [DATA_W-1:0]  issueStData_i,
  input  logic [LSQ_W-1:0]   issueLsqID_i,
  input  logic [AL_W-1:0]    issueAlID_i,
  input  logic [PHY_W-1:0]   issuePhyDest_i,
  output logic               memValid_o,
  input  logic               memReady_i,
  output logic [VADDR_W-1:0] memAddr_o,
  output logic [1:0]         memSize_o,
  output logic               memIsLoad_o,
  output logic               memIsSigned_o,
  output logic [DATA_W-1:0]  memStData_o,
  output logic [LSQ_W-1:0]   memLsqID_o,
  output logic [AL_W-1:0]    memAlID_o,
  output logic [PHY_W-1:0]   memPhyDest_o,
  output logic               excValid_o,
  output logic [3:0]         excCause_o,
  output logic [VADDR_W-1:0] excAddr_o,
  output logic [AL_W-1:0]    excAlID_o
);

  logic [DATA_W-1:0]  offsetExt;
  logic [DATA_W-1:0]  fullSum;
  logic               sumUnused;
  logic [VADDR_W-1:0] effAddr;
  memSizeE            issueSize;
  logic               misaligned;
  logic               accept;
  logic               bufReady;
  agenPkt             inPkt;
  agenPkt             memPkt;

  logic               excValidReg;
  logic [3:0]         excCauseReg;
  logic [VADDR_W-1:0] excAddrReg;
  logic [AL_W-1:0]    excAlIdReg;

  assign offsetExt = {{(DATA_W-12){issueOffset_i[11]}}, issueOffset_i};
  assign fullSum   = issueBase_i + offsetExt;
  assign effAddr   = fullSum[VADDR_W-1:0];
  // Bits above the virtual address width are intentionally dropped.
  assign sumUnused = ^fullSum[DATA_W-1:VADDR_W];

  assign issueSize  = memSizeE'(issueSize_i);
  assign misaligned = isMisaligned(issueSize, effAddr[2:0]);
  assign accept     = issueValid_i && bufReady;

  always_comb begin
    inPkt          = '0;
    inPkt.addr     = effAddr;
    inPkt.size     = issueSize;
    inPkt.isLoad   = issueIsLoad_i;
    inPkt.isSigned = issueIsSigned_i;
    inPkt.stData   = issueStData_i;
    inPkt.lsqId    = issueLsqID_i;
    inPkt.alId     = issueAlID_i;
    inPkt.phyDest  = issuePhyDest_i;
  end

  agen_skid_buf #(
    .W($bits(agenPkt))
  ) u_skidBuf (
    .clk      (clk),
    .reset    (reset),
    .flush    (recoverFlag_i),
    .inValid  (issueValid_i && !misaligned),
    .inReady  (bufReady),
    .inData   (inPkt),
    .outValid (memValid_o),
    .outReady (memReady_i),
    .outData  (memPkt)
  );

  // Exception path is independent of memReady_i: a misaligned op is
  // accepted whenever the issue lane is ready and pulses for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      excValidReg <= 1'b0;
      excCauseReg <= '0;
      excAddrReg  <= '0;
      excAlIdReg  <= '0;
    end else begin
      excValidReg <= accept && misaligned && !recoverFlag_i;
      if (accept && misaligned) begin
        excCauseReg <= issueIsLoad_i ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        excAddrReg  <= effAddr;
        excAlIdReg  <= issueAlID_i;
      end
    end
  end

  assign issueReady_o  = bufReady;
  assign memAddr_o     = memPkt.addr;
  assign memSize_o     = memPkt.size;
  assign memIsLoad_o   = memPkt.isLoad;
  assign memIsSigned_o = memPkt.isSigned;
  assign memStData_o   = memPkt.stData;
  assign memLsqID_o    = memPkt.lsqId;
  assign memAlID_o     = memPkt.alId;
  assign memPhyDest_o  = memPkt.phyDest;
  assign excValid_o    = excValidReg;
  assign excCause_o    = excCauseReg;
  assign excAddr_o     = excAddrReg;
  assign excAlID_o     = excAlIdReg;

endmodule

// File: tb/tb_agen_stage.sv
module tb_agen_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        recoverFlag_i;
  logic        issueValid_i;
  logic        issueReady_o;
  logic [63:0] issueBase_i;
  logic [11:0] issueOffset_i;
  logic [1:0]  issueSize_i;
  logic        issueIsLoad_i;
  logic        issueIsSigned_i;
  logic [63:0] issueStData_i;
  logic [4:0]  issueLsqID_i;
  logic [6:0]  issueAlID_i;
  logic [6:0]  issuePhyDest_i;
  logic        memValid_o;
  logic        memReady_i;
  logic [38:0] memAddr_o;
  logic [1:0]  memSize_o;
  logic        memIsLoad_o;
  logic        memIsSigned_o;
  logic [63:0] memStData_o;
  logic [4:0]  memLsqID_o;
  logic [6:0]  memAlID_o;
  logic [6:0]  memPhyDest_o;
  logic        excValid_o;
  logic [3:0]  excCause_o;
  logic [38:0] excAddr_o;
  logic [6:0]  excAlID_o;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  agen_stage dut (
    .clk             (clk),
    .reset           (reset),
    .recoverFlag_i   (recoverFlag_i),
    .issueValid_i    (issueValid_i),
    .issueReady_o    (issueReady_o),
    .issueBase_i     (issueBase_i),
    .issueOffset_i   (issueOffset_i),
    .issueSize_i     (issueSize_i),
    .issueIsLoad_i   (issueIsLoad_i),
    .issueIsSigned_i (issueIsSigned_i),
    .issueStData_i   (issueStData_i),
    .issueLsqID_i    (issueLsqID_i),
    .issueAlID_i     (issueAlID_i),
    .issuePhyDest_i  (issuePhyDest_i),
    .memValid_o      (memValid_o),
    .memReady_i      (memReady_i),
    .memAddr_o       (memAddr_o),
    .memSize_o       (memSize_o),
    .memIsLoad_o     (memIsLoad_o),
    .memIsSigned_o   (memIsSigned_o),
    .memStData_o     (memStData_o),
    .memLsqID_o      (memLsqID_o),
    .memAlID_o       (memAlID_o),
    .memPhyDest_o    (memPhyDest_o),
    .excValid_o      (excValid_o),
    .excCause_o      (excCause_o),
    .excAddr_o       (excAddr_o),
    .excAlID_o       (excAlID_o)
  );

  task automatic expectEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [63:0] base, input logic [11:0] off, input logic [1:0] size,
                       input logic isLoad, input logic [4:0] lsq, input logic [6:0] al,
                       input logic [6:0] phy, input logic [63:0] stData);
    issueValid_i    = 1'b1;
    issueBase_i     = base;
    issueOffset_i   = off;
    issueSize_i     = size;
    issueIsLoad_i   = isLoad;
    issueIsSigned_i = isLoad;
    issueLsqID_i    = lsq;
    issueAlID_i     = al;
    issuePhyDest_i  = phy;
    issueStData_i   = stData;
  endtask

  initial begin
    reset = 1'b1;
    recoverFlag_i = 1'b0;
    memReady_i = 1'b1;
    issueValid_i = 1'b0;
    issueBase_i = '0;
    issueOffset_i = '0;
    issueSize_i = '0;
    issueIsLoad_i = 1'b0;
    issueIsSigned_i = 1'b0;
    issueStData_i = '0;
    issueLsqID_i = '0;
    issueAlID_i = '0;
    issuePhyDest_i = '0;

    // Reset state
    #2;
    expectEq("rst_memValid", memValid_o, 1'b0);
    expectEq("rst_excValid", excValid_o, 1'b0);
    expectEq("rst_memAddr", memAddr_o, 39'h0);
    expectEq("rst_excAddr", excAddr_o, 39'h0);
    expectEq("rst_issueReady", issueReady_o, 1'b1);
    tick();
    reset = 1'b0;
    tick();

    // Word load: 0x1000 - 4 = 0xFFC
    setOp(64'h1000, 12'hFFC, 2'd2, 1'b1, 5'd1, 7'd3, 7'd9, 64'h0);
    tick();
    issueValid_i = 1'b0;
    expectEq("ld_memValid", memValid_o, 1'b1);
    expectEq("ld_memAddr", memAddr_o, 39'hFFC);
    expectEq("ld_memIsLoad", memIsLoad_o, 1'b1);
    expectEq("ld_memSize", memSize_o, 2'd2);
    expectEq("ld_memAlID", memAlID_o, 7'd3);
    expectEq("ld_memPhyDest", memPhyDest_o, 7'd9);
    expectEq("ld_excValid", excValid_o, 1'b0);
    tick();
    expectEq("ld_drained", memValid_o, 1'b0);

    // Misaligned double store
    setOp(64'h2003, 12'h000, 2'd3, 1'b0, 5'd2, 7'd5, 7'd0, 64'hDEAD);
    tick();
    issueValid_i = 1'b0;
    expectEq("mst_excValid", excValid_o, 1'b1);
    expectEq("mst_excCause", excCause_o, 4'd6);
    expectEq("mst_excAddr", excAddr_o, 39'h2003);
    expectEq("mst_excAlID", excAlID_o, 7'd5);
    expectEq("mst_memValid", memValid_o, 1'b0);
    tick();
    expectEq("mst_excPulse", excValid_o, 1'b0);
    expectEq("mst_memValid2", memValid_o, 1'b0);

    // Misaligned half load: 0x10 + 1 = 0x11, while LSU is stalled
    memReady_i = 1'b0;
    setOp(64'h10, 12'h001, 2'd1, 1'b1, 5'd3, 7'd6, 7'd4, 64'h0);
    tick();
    issueValid_i = 1'b0;
    expectEq("mld_excCause", excCause_o, 4'd4);
    expectEq("mld_excAddr", excAddr_o, 39'h11);
    expectEq("mld_memValid", memValid_o, 1'b0);
    tick();

    // Backpressure: A, B, C back to back with LSU stalled
    setOp(64'h100, 12'h000, 2'd3, 1'b1, 5'd10, 7'd10, 7'd1, 64'h0);
    tick();
    expectEq("bp_A_out", memAddr_o, 39'h100);
    expectEq("bp_A_ready", issueReady_o, 1'b1);
    setOp(64'h108, 12'h000, 2'd3, 1'b0, 5'd11, 7'd11, 7'd0, 64'hBBBB);
    tick();
    expectEq("bp_B_held", memAddr_o, 39'h100);
    expectEq("bp_B_readyLow", issueReady_o, 1'b0);
    setOp(64'h110, 12'h000, 2'd3, 1'b1, 5'd12, 7'd12, 7'd2, 64'h0);
    tick();
    expectEq("bp_C_held", memAddr_o, 39'h100);
    expectEq("bp_C_heldLsq", memLsqID_o, 5'd10);
    expectEq("bp_C_readyLow", issueReady_o, 1'b0);
    memReady_i = 1'b1;
    tick();
    expectEq("bp_B_out", memAddr_o, 39'h108);
    expectEq("bp_B_stData", memStData_o, 64'hBBBB);
    expectEq("bp_B_ready", issueReady_o, 1'b1);
    tick();
    issueValid_i = 1'b0;
    expectEq("bp_C_out", memAddr_o, 39'h110);
    expectEq("bp_C_valid", memValid_o, 1'b1);
    tick();
    expectEq("bp_empty", memValid_o, 1'b0);

    // Wrap-around: (2^39 - 2) + 4 = 2
    setOp(64'h7F_FFFF_FFFE, 12'h004, 2'd0, 1'b1, 5'd4, 7'd20, 7'd5, 64'h0);
    tick();
    issueValid_i = 1'b0;
    expectEq("wrap_memAddr", memAddr_o, 39'h2);
    expectEq("wrap_excValid", excValid_o, 1'b0);
    tick();

    // Recovery with OUT and SKID full
    memReady_i = 1'b0;
    setOp(64'h200, 12'h000, 2'd2, 1'b1, 5'd5, 7'd30, 7'd6, 64'h0);
    tick();
    setOp(64'h204, 12'h000, 2'd2, 1'b1, 5'd6, 7'd31, 7'd7, 64'h0);
    tick();
    expectEq("rec_full", issueReady_o, 1'b0);
    issueValid_i = 1'b0;
    recoverFlag_i = 1'b1;
    tick();
    recoverFlag_i = 1'b0;
    memReady_i = 1'b1;
    expectEq("rec_memValid", memValid_o, 1'b0);
    expectEq("rec_issueReady", issueReady_o, 1'b1);
    tick();
    expectEq("rec_noStale", memValid_o, 1'b0);

    // Op accepted in the same cycle as recovery is dropped (aligned and misaligned)
    setOp(64'h300, 12'h000, 2'd3, 1'b1, 5'd7, 7'd40, 7'd8, 64'h0);
    recoverFlag_i = 1'b1;
    tick();
    expectEq("recAcc_memValid", memValid_o, 1'b0);
    setOp(64'h301, 12'h000, 2'd3, 1'b1, 5'd7, 7'd41, 7'd8, 64'h0);
    tick();
    recoverFlag_i = 1'b0;
    issueValid_i = 1'b0;
    expectEq("recAcc_excValid", excValid_o, 1'b0);
    tick();

    // Asynchronous reset between edges while memValid_o is high
    memReady_i = 1'b0;
    setOp(64'h400, 12'h000, 2'd3, 1'b1, 5'd8, 7'd50, 7'd9, 64'h0);
    tick();
    setOp(64'h408, 12'h000, 2'd3, 1'b1, 5'd9, 7'd51, 7'd10, 64'h0);
    tick();
    issueValid_i = 1'b0;
    expectEq("ar_before", memValid_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    expectEq("ar_memValid", memValid_o, 1'b0);
    expectEq("ar_memAddr", memAddr_o, 39'h0);
    #2;
    reset = 1'b0;
    memReady_i = 1'b1;
    tick();
    expectEq("ar_issueReady", issueReady_o, 1'b1);
    expectEq("ar_noStale", memValid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
